// File: rtl/relay_frame_packer_pkg.sv
// rtl/relay_frame_packer_pkg.sv - shared types, constants and helpers for the relay frame packer
package relay_frame_packer_pkg;

    typedef enum logic [2:0] {
        MODE_SNIFFER     = 3'd0,
        MODE_FAKE_READER = 3'd1,
        MODE_FAKE_TAG    = 3'd2,
        MODE_TAGSIM_MOD  = 3'd3,
        MODE_READER_MOD  = 3'd4
    } relay_mode_t;

    // div_counter compare value that yields the 847.5 kHz bit tick
    localparam int unsigned BIT_TICK_CMP = 8;

    localparam int unsigned ENTRY_W       = 12;
    localparam int unsigned ENTRY_LAST    = 11;
    localparam int unsigned ENTRY_NBITS_H = 10;
    localparam int unsigned ENTRY_NBITS_L = 8;
    localparam int unsigned ENTRY_DATA_H  = 7;
    localparam int unsigned ENTRY_DATA_L  = 0;

    typedef struct packed {
        logic       last;
        logic [2:0] nbits;
        logic [7:0] data;
    } fifo_entry_t;

    // Left-align the n most recent bits of a partial byte, zero-filling the low bits
    function automatic logic [7:0] align_partial(input logic [7:0] sr, input logic [2:0] n);
        logic [7:0] r;
        r = 8'h00;
        if (n != 3'd0) begin
            r = sr << (4'd8 - {1'b0, n});
        end
        return r;
    endfunction

endpackage

// File: rtl/relay_sync_fifo.sv
// rtl/relay_sync_fifo.sv - synchronous show-ahead FIFO with full/empty/count
module relay_sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Entry storage; no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relay_frame_packer.sv
// rtl/relay_frame_packer.sv - packs relay bits into MSB-first bytes with frame terminators
module relay_frame_packer
    import relay_frame_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       bit_strobe,
    input  logic       bit_in,
    input  logic       mod_active,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [2:0] out_nbits,
    output logic [7:0] out_data,
    output logic       overflow,
    input  logic       clear_overflow
);

    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic             mod_active_d;
    logic             capture;
    logic             frame_end;
    logic             byte_push;
    logic             push_req;
    fifo_entry_t      push_entry;
    fifo_entry_t      head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic             pop;
    logic             drop;

    assign capture   = enable && mod_active && bit_strobe;
    assign frame_end = enable && !mod_active && mod_active_d;
    assign byte_push = capture && (bit_cnt == 3'd7);
    // byte_push needs mod_active=1 and frame_end needs mod_active=0, so they never collide
    assign push_req  = byte_push || frame_end;
    assign pop       = out_valid && out_ready;
    assign drop      = push_req && fifo_full && !pop;

    // Select the entry to enqueue: a completed byte or the frame terminator
    always_comb begin
        push_entry = '0;
        if (frame_end) begin
            push_entry.last  = 1'b1;
            push_entry.nbits = bit_cnt;
            push_entry.data  = align_partial(shift_reg, bit_cnt);
        end else begin
            push_entry.data  = {shift_reg[6:0], bit_in};
        end
    end

    // Bit accumulation and frame-window edge tracking; disable discards any partial frame
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            mod_active_d <= 1'b0;
        end else begin
            mod_active_d <= mod_active;
            if (frame_end) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (capture) begin
                shift_reg <= {shift_reg[6:0], bit_in};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // Sticky drop flag; a same-cycle drop beats the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    relay_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign head_entry = head_bits;
    assign out_valid  = !fifo_empty;
    assign out_last   = out_valid && head_entry.last;
    assign out_nbits  = out_valid ? head_entry.nbits : 3'd0;
    assign out_data   = out_valid ? head_entry.data  : 8'h00;

endmodule

// File: tb/tb_relay_frame_packer.sv
// tb/tb_relay_frame_packer.sv - scoreboard bench for relay_frame_packer
module tb_relay_frame_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       bit_strobe;
    logic       bit_in;
    logic       mod_active;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [2:0] out_nbits;
    logic [7:0] out_data;
    logic       overflow;
    logic       clear_overflow;

    int checks   = 0;
    int failures = 0;

    logic [11:0] sb[$];
    logic [7:0]  m_acc;
    int          m_cnt;
    bit          stall_mode;
    int          kept;

    relay_frame_packer #(.FIFO_DEPTH(16), .FIFO_AW(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .bit_strobe     (bit_strobe),
        .bit_in         (bit_in),
        .mod_active     (mod_active),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_nbits      (out_nbits),
        .out_data       (out_data),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_without_expected", 32'd0, 32'd1);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("pop_entry", {20'd0, out_last, out_nbits, out_data}, {20'd0, e});
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_push(input logic [11:0] e);
        if (stall_mode) begin
            if (kept < 16) begin
                sb.push_back(e);
                kept++;
            end
        end else begin
            sb.push_back(e);
        end
    endtask

    task automatic send_bits(input logic [159:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bit_strobe = 1'b1;
            bit_in     = data[n-1-i];
            m_acc      = {m_acc[6:0], data[n-1-i]};
            m_cnt++;
            if (m_cnt == 8) begin
                expect_push({4'b0000, m_acc});
                m_cnt = 0;
                m_acc = 8'h00;
            end
            cyc(1);
            bit_strobe = 1'b0;
            cyc(1);
        end
    endtask

    task automatic frame_start();
        m_acc = 8'h00;
        m_cnt = 0;
        mod_active = 1'b1;
        cyc(1);
    endtask

    task automatic frame_stop();
        logic [7:0] al;
        al = (m_cnt == 0) ? 8'h00 : 8'(m_acc << (8 - m_cnt));
        mod_active = 1'b0;
        expect_push({1'b1, 3'(m_cnt), al});
        m_acc = 8'h00;
        m_cnt = 0;
        cyc(2);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 400) begin
            cyc(1);
            t++;
        end
        check("drain_done", {31'd0, (t < 400)}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; bit_strobe = 1'b0; bit_in = 1'b0;
        mod_active = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        stall_mode = 1'b0; kept = 0; m_acc = 8'h00; m_cnt = 0;
        cyc(3);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_nbits", {29'd0, out_nbits}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
        cyc(2);

        // 16-bit frame C0 3A
        frame_start();
        send_bits(160'hC03A, 16);
        frame_stop();
        wait_drain();
        check("f1_overflow", {31'd0, overflow}, 32'd0);

        // 11-bit frame 1010_1100_101
        frame_start();
        send_bits(160'b10101100101, 11);
        frame_stop();
        wait_drain();

        // 20 bytes with consumer stalled: 16 kept, rest dropped
        out_ready = 1'b0; stall_mode = 1'b1; kept = 0;
        frame_start();
        for (int b = 0; b < 20; b++) send_bits(160'(8'h10 + b), 8);
        frame_stop();
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count", {27'd0, u_dut.fifo_count}, 32'd16);
        stall_mode = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        clear_overflow = 1'b1;
        cyc(1);
        clear_overflow = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0; stall_mode = 1'b1; kept = 0;
        frame_start();
        send_bits(160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128);
        check("full_count", {27'd0, u_dut.fifo_count}, 32'd16);
        stall_mode = 1'b0;
        send_bits(160'h4B, 7);
        bit_strobe = 1'b1; bit_in = 1'b0; out_ready = 1'b1;
        m_acc = {m_acc[6:0], 1'b0};
        sb.push_back({4'b0000, m_acc});
        m_acc = 8'h00; m_cnt = 0;
        cyc(1);
        bit_strobe = 1'b0; out_ready = 1'b0;
        check("pp_count", {27'd0, u_dut.fifo_count}, 32'd16);
        check("pp_overflow", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        frame_stop();
        wait_drain();

        // enable dropped mid-frame, then an FF frame
        frame_start();
        send_bits(160'b10110, 5);
        enable = 1'b0;
        cyc(1);
        mod_active = 1'b0;
        cyc(1);
        enable = 1'b1;
        cyc(1);
        check("en_no_entry", {31'd0, out_valid}, 32'd0);
        frame_start();
        send_bits(160'hFF, 8);
        frame_stop();
        wait_drain();

        // reset with 3 entries queued and 4 bits pending
        out_ready = 1'b0;
        frame_start();
        send_bits(160'hA5C3E_1, 28);
        check("pre_rst_count", {27'd0, u_dut.fifo_count}, 32'd3);
        mod_active = 1'b0; reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        sb.delete(); m_acc = 8'h00; m_cnt = 0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        frame_start();
        send_bits(160'h5A, 8);
        frame_stop();
        wait_drain();

        check("final_sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
